// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-channel edge-event scheduler. Each asynchronous input line is
// synchronised, and its rising and/or falling edges (selected per channel by
// edge_mode) are detected. Each detected edge is latched as a pending event
// together with a timestamp and its polarity. Pending events are then
// serialised, one at a time and in round-robin order, onto a valid/ready
// event port.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   rst         synchronous, active-high reset
//   data_in     [N_CH]     asynchronous input lines
//   enable      1 = capture new edges; 0 = block capture (pending events still drain)
//   edge_mode   [2*N_CH]   per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   evt_valid   an event is being presented
//   evt_ready   consumer accepts the presented event when evt_valid is high
//   evt_ch      channel of the presented event
//   evt_rising  1 = rising edge, 0 = falling edge
//   evt_ts      timestamp taken when the edge became pending
//   overflow    [N_CH] sticky; set when an edge is lost on an already-pending channel
//   ovf_clr     single-cycle pulse that clears every overflow bit
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int TS_W        = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      data_in,
  input  logic                 enable,
  input  logic [2*N_CH-1:0]    edge_mode,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CH_W-1:0]      evt_ch,
  output logic                 evt_rising,
  output logic [TS_W-1:0]      evt_ts,
  output logic [N_CH-1:0]      overflow,
  input  logic                 ovf_clr
);

  // Capture stays off for SYNC_STAGES+1 cycles after reset. This lets the
  // synchroniser and the prev register fill with the real line level, so a
  // line that is already high at reset never looks like a rising edge.
  localparam int WARM   = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM + 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser, edge detector and timestamp counter
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_reg;
  logic [N_CH-1:0]                  sync_out;
  logic [N_CH-1:0]                  prev_reg;
  logic [WARM_W-1:0]                warm_reg;
  logic [TS_W-1:0]                  ts_reg;

  logic [N_CH-1:0] rise_det;
  logic [N_CH-1:0] fall_det;
  logic            capture_ok;
  logic [N_CH-1:0] edge_next;

  // Edges detected in the previous cycle. This stage gives the fixed
  // SYNC_STAGES+1 latency from the input sample to the pending flag.
  logic [N_CH-1:0] edge_reg;
  logic [N_CH-1:0] edge_pol_reg;

  assign sync_out   = sync_reg[SYNC_STAGES-1];
  assign capture_ok = enable && (warm_reg == '0);
  assign edge_next  = (rise_det | fall_det) & {N_CH{capture_ok}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= '0;
      prev_reg     <= '0;
      warm_reg     <= WARM_W'(WARM);
      ts_reg       <= '0;
      edge_reg     <= '0;
      edge_pol_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], data_in};
      // prev follows sync unconditionally, so enabling a channel again
      // (or changing its mode) never produces a stale edge.
      prev_reg <= sync_out;
      if (warm_reg != '0) begin
        warm_reg <= warm_reg - WARM_W'(1);
      end
      ts_reg       <= ts_reg + TS_W'(1);
      edge_reg     <= edge_next;
      edge_pol_reg <= rise_det;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin grant: the search starts one past the last granted channel
  // -------------------------------------------------------------------------
  state_t          state_reg;
  logic [CH_W-1:0] rr_reg;
  logic [N_CH-1:0] pending_reg;
  logic [N_CH-1:0] pend_pol_reg;
  logic [TS_W-1:0] pend_ts_reg [N_CH];
  logic [N_CH-1:0] overflow_reg;

  logic            grant_found;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] cand;
  logic            grant_fire;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (int'(rr_reg) + k >= N_CH) begin
        cand = CH_W'(int'(rr_reg) + k - N_CH);
      end else begin
        cand = CH_W'(int'(rr_reg) + k);
      end
      if (!grant_found && pending_reg[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A grant happens from IDLE, or on a handshake while presenting (back-to-back).
  assign grant_fire = grant_found && ((state_reg == S_IDLE) || evt_ready);

  // -------------------------------------------------------------------------
  // Per-channel pending slot and overflow flag
  // -------------------------------------------------------------------------
  logic [N_CH-1:0] grant_clr;
  logic [N_CH-1:0] load_slot;
  logic [N_CH-1:0] ovf_set;
  logic [N_CH-1:0] pending_next;
  logic [N_CH-1:0] overflow_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign rise_det[gi]  = sync_out[gi] & ~prev_reg[gi] & edge_mode[2*gi];
      assign fall_det[gi]  = ~sync_out[gi] & prev_reg[gi] & edge_mode[2*gi+1];
      assign grant_clr[gi] = grant_fire && (grant_idx == CH_W'(gi));
      // The slot takes a new edge when it is empty, or when its current
      // event leaves in this same cycle.
      assign load_slot[gi] = edge_reg[gi] & (~pending_reg[gi] | grant_clr[gi]);
      // Otherwise the edge is lost; the oldest event is kept.
      assign ovf_set[gi]   = edge_reg[gi] & pending_reg[gi] & ~grant_clr[gi];
    end
  endgenerate

  assign pending_next  = (pending_reg & ~grant_clr) | edge_reg;
  // A new overflow beats a clear that arrives in the same cycle.
  assign overflow_next = ovf_set | (overflow_reg & ~{N_CH{ovf_clr}});
  assign overflow      = overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg  <= '0;
      pend_pol_reg <= '0;
      overflow_reg <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pend_ts_reg[i] <= '0;
      end
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      for (int i = 0; i < N_CH; i++) begin
        if (load_slot[i]) begin
          pend_ts_reg[i]  <= ts_reg;
          pend_pol_reg[i] <= edge_pol_reg[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output FSM; the evt_* outputs are registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      rr_reg     <= CH_W'(N_CH - 1);
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_rising <= 1'b0;
      evt_ts     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            state_reg  <= S_PRESENT;
            evt_valid  <= 1'b1;
            evt_ch     <= grant_idx;
            evt_rising <= pend_pol_reg[grant_idx];
            evt_ts     <= pend_ts_reg[grant_idx];
            rr_reg     <= grant_idx;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            if (grant_found) begin
              evt_ch     <= grant_idx;
              evt_rising <= pend_pol_reg[grant_idx];
              evt_ts     <= pend_ts_reg[grant_idx];
              rr_reg     <= grant_idx;
            end else begin
              state_reg <= S_IDLE;
              evt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Directed bench for edge_event_arbiter. It uses N_CH=4, TS_W=4 and
// SYNC_STAGES=2. A table of per-cycle vectors covers warm-up, basic latency,
// the falling/off/enable masks and timestamp wrap inside the table. Short
// hand-written sequences cover the round-robin order, overflow, wrap across
// two channels and a reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;

  localparam int N_CH = 4;
  localparam int TS_W = 4;
  localparam int SS   = 2;
  localparam int CH_W = 2;
  localparam int NROW = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   data_in;
  logic              enable;
  logic [2*N_CH-1:0] edge_mode;
  logic              evt_valid;
  logic              evt_ready;
  logic [CH_W-1:0]   evt_ch;
  logic              evt_rising;
  logic [TS_W-1:0]   evt_ts;
  logic [N_CH-1:0]   overflow;
  logic              ovf_clr;

  always #5 clk = ~clk;

  edge_event_arbiter #(
    .N_CH        (N_CH),
    .TS_W        (TS_W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .enable     (enable),
    .edge_mode  (edge_mode),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_rising (evt_rising),
    .evt_ts     (evt_ts),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // Reference free-running timestamp: 0 in reset, +1 every cycle after.
  logic [TS_W-1:0] ref_ts;
  always @(posedge clk) begin
    if (rst) ref_ts <= '0;
    else     ref_ts <= ref_ts + 4'd1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] data;
    logic [7:0] mode;
    logic       en;
    logic       exp_valid;
    logic [1:0] exp_ch;
    logic       exp_rising;
    logic [3:0] exp_ts;
  } vec_t;

  vec_t tbl [1:NROW];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (evt_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout actual=%0b required=1 within %0d cycles", name, evt_valid, budget);
    end
  endtask

  task automatic fill(input int lo, input int hi, input logic [3:0] d,
                      input logic [7:0] m, input logic e);
    for (int r = lo; r <= hi; r++) begin
      tbl[r].data       = d;
      tbl[r].mode       = m;
      tbl[r].en         = e;
      tbl[r].exp_valid  = 1'b0;
      tbl[r].exp_ch     = 2'd0;
      tbl[r].exp_rising = 1'b0;
      tbl[r].exp_ts     = 4'd0;
    end
  endtask

  task automatic expect_evt(input int r, input logic [1:0] ch, input logic rising,
                            input logic [3:0] ts);
    tbl[r].exp_valid  = 1'b1;
    tbl[r].exp_ch     = ch;
    tbl[r].exp_rising = rising;
    tbl[r].exp_ts     = ts;
  endtask

  initial begin
    logic [3:0] rise_exp;
    logic [3:0] ts1;
    logic [3:0] ts2;
    int         n;

    // Row r drives inputs in the cycle before edge Er (counted from reset
    // release) and checks outputs right after Er.
    // Rows 1-6: ch0 high through reset, all modes "both": no event.
    fill(1, 6, 4'b0001, 8'hFF, 1'b1);
    // Rows 7-12: ch2 rise sampled at E7 -> pending E10 (ts 9) -> valid at E11.
    fill(7, 12, 4'b0101, 8'h10, 1'b1);
    expect_evt(11, 2'd2, 1'b1, 4'd9);
    // Rows 13-23: ch3 falling-only; high for 5 cycles, fall sampled at E18 -> ts 20 mod 16.
    fill(13, 17, 4'b1101, 8'h80, 1'b1);
    fill(18, 23, 4'b0101, 8'h80, 1'b1);
    expect_evt(22, 2'd3, 1'b0, 4'd4);
    // Rows 24-31: ch3 mode off: pulse gives nothing.
    fill(24, 26, 4'b1101, 8'h00, 1'b1);
    fill(27, 31, 4'b0101, 8'h00, 1'b1);
    // Rows 32-40: ch0 falls while enable=0, then enable returns: nothing.
    fill(32, 35, 4'b0100, 8'hFF, 1'b0);
    fill(36, 40, 4'b0100, 8'hFF, 1'b1);

    // Reset held 3 cycles with ch0 high.
    rst       = 1'b1;
    data_in   = 4'b0001;
    edge_mode = 8'hFF;
    enable    = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) step();
    chk("reset evt_valid", evt_valid, 1'b0);
    chk("reset evt_ch", evt_ch, 2'd0);
    chk("reset evt_rising", evt_rising, 1'b0);
    chk("reset evt_ts", evt_ts, 4'd0);
    chk("reset overflow", overflow, 4'd0);
    rst = 1'b0;

    for (int r = 1; r <= NROW; r++) begin
      data_in   = tbl[r].data;
      edge_mode = tbl[r].mode;
      enable    = tbl[r].en;
      step();
      chk($sformatf("row%0d evt_valid", r), evt_valid, tbl[r].exp_valid);
      chk($sformatf("row%0d overflow", r), overflow, 4'd0);
      if (tbl[r].exp_valid) begin
        chk($sformatf("row%0d evt_ch", r), evt_ch, tbl[r].exp_ch);
        chk($sformatf("row%0d evt_rising", r), evt_rising, tbl[r].exp_rising);
        chk($sformatf("row%0d evt_ts", r), evt_ts, tbl[r].exp_ts);
      end
    end

    // Round robin: all four channels at once -> 0,1,2,3 back-to-back.
    rise_exp = 4'b1011;
    data_in  = 4'b1011;
    wait_valid("rr4 first valid", 10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr4 slot%0d evt_valid", i), evt_valid, 1'b1);
      chk($sformatf("rr4 slot%0d evt_ch", i), evt_ch, i[1:0]);
      chk($sformatf("rr4 slot%0d evt_rising", i), evt_rising, rise_exp[i]);
      step();
    end
    chk("rr4 end evt_valid", evt_valid, 1'b0);
    // The pointer now sits at 3, so ch1 goes before ch3.
    data_in = 4'b0001;
    wait_valid("rr2 first valid", 10);
    chk("rr2 first evt_ch", evt_ch, 2'd1);
    chk("rr2 first evt_rising", evt_rising, 1'b0);
    step();
    chk("rr2 second evt_valid", evt_valid, 1'b1);
    chk("rr2 second evt_ch", evt_ch, 2'd3);
    step();
    chk("rr2 end evt_valid", evt_valid, 1'b0);

    // Overflow: consumer stalled, ch1 rising only.
    evt_ready = 1'b0;
    edge_mode = 8'hF7;
    data_in   = 4'b0011;
    repeat (3) step();
    ts1 = ref_ts;
    wait_valid("ovf first valid", 5);
    chk("ovf first evt_ch", evt_ch, 2'd1);
    chk("ovf first evt_ts", evt_ts, ts1);
    // Second edge becomes pending behind the presented one.
    data_in = 4'b0001;
    repeat (2) step();
    data_in = 4'b0011;
    repeat (3) step();
    ts2 = ref_ts;
    repeat (3) step();
    chk("ovf second no overflow", overflow, 4'b0000);
    chk("ovf held evt_valid", evt_valid, 1'b1);
    chk("ovf held evt_ts", evt_ts, ts1);
    // Third edge hits a pending channel.
    data_in = 4'b0001;
    repeat (2) step();
    data_in = 4'b0011;
    repeat (4) step();
    chk("ovf third overflow", overflow, 4'b0010);
    chk("ovf third evt_ch", evt_ch, 2'd1);
    // Fourth edge with ovf_clr in the same cycle: set wins.
    data_in = 4'b0001;
    repeat (2) step();
    data_in = 4'b0011;
    repeat (3) step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf set beats clr", overflow, 4'b0010);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr clears", overflow, 4'b0000);
    // Drain: the pending event still carries the second edge's timestamp.
    evt_ready = 1'b1;
    step();
    chk("ovf drain evt_valid", evt_valid, 1'b1);
    chk("ovf drain evt_ch", evt_ch, 2'd1);
    chk("ovf drain evt_rising", evt_rising, 1'b1);
    chk("ovf drain evt_ts", evt_ts, ts2);
    step();
    chk("ovf drain end evt_valid", evt_valid, 1'b0);

    // Timestamp wrap: ch0 pending at ts 15, ch1 one cycle later at ts 0.
    edge_mode = 8'hFF;
    n = 0;
    while (ref_ts != 4'd12 && n < 40) begin
      step();
      n++;
    end
    data_in = 4'b0010;
    step();
    data_in = 4'b0000;
    wait_valid("wrap first valid", 10);
    chk("wrap first evt_ch", evt_ch, 2'd0);
    chk("wrap first evt_rising", evt_rising, 1'b0);
    chk("wrap first evt_ts", evt_ts, 4'd15);
    step();
    chk("wrap second evt_valid", evt_valid, 1'b1);
    chk("wrap second evt_ch", evt_ch, 2'd1);
    chk("wrap second evt_ts", evt_ts, 4'd0);
    step();
    chk("wrap end evt_valid", evt_valid, 1'b0);

    // Reset while an event is presented and another is pending.
    evt_ready = 1'b0;
    data_in   = 4'b1100;
    wait_valid("midrst valid", 10);
    chk("midrst evt_ch", evt_ch, 2'd2);
    rst = 1'b1;
    step();
    chk("midrst evt_valid", evt_valid, 1'b0);
    rst       = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("midrst quiet%0d evt_valid", i), evt_valid, 1'b0);
    end
    chk("midrst overflow", overflow, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
